// File: rtl/relu_pkg.sv
// Shared constants, index types and reader state encoding for the ReLU layer readers.
package relu_pkg;

   localparam int RELU_NUM_MAPS   = 8;
   localparam int RELU_X          = 24;
   localparam int RELU_Y          = 24;
   localparam int RELU_DATA_WIDTH = 45;

   typedef logic [2:0] map_idx_t;
   typedef logic [4:0] row_idx_t;
   typedef logic [4:0] col_idx_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ENABLE = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } rsr_state_t;

endpackage

// File: rtl/relu_stream_reader_addr_counter.sv
// Nested map/row/col element counter, col fastest; saturates on the final element of a frame.
// Advances one element per cycle when adv is high; holds otherwise.
module rsr_addr_counter
   import relu_pkg::*;
#(
   parameter int NUM_MAPS = RELU_NUM_MAPS,
   parameter int MAP_X    = RELU_X,
   parameter int MAP_Y    = RELU_Y
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       adv,
   output logic [2:0] map,
   output logic [4:0] row,
   output logic [4:0] col,
   output logic       map_last,
   output logic       frame_last
);

   localparam map_idx_t MAP_MAX = map_idx_t'(NUM_MAPS - 1);
   localparam row_idx_t ROW_MAX = row_idx_t'(MAP_X - 1);
   localparam col_idx_t COL_MAX = col_idx_t'(MAP_Y - 1);

   assign map_last   = (row == ROW_MAX) && (col == COL_MAX);
   assign frame_last = map_last && (map == MAP_MAX);

   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         map <= '0;
         row <= '0;
         col <= '0;
      end else if (adv && !frame_last) begin
         if (col == COL_MAX) begin
            col <= '0;
            if (row == ROW_MAX) begin
               row <= '0;
               map <= map + 1'b1;
            end else begin
               row <= row + 1'b1;
            end
         end else begin
            col <= col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/relu_stream_reader.sv
// Starts the ReLU layer, waits for done, then streams every element of the frame out.
// One element per cycle with out_ready high; output register and rd_* hold under backpressure.
module relu_stream_reader
   import relu_pkg::*;
#(
   parameter int NUM_MAPS   = RELU_NUM_MAPS,
   parameter int MAP_X      = RELU_X,
   parameter int MAP_Y      = RELU_Y,
   parameter int DATA_WIDTH = RELU_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  relu_enable,
   input  logic                  relu_done,
   output logic [2:0]            rd_map,
   output logic [4:0]            rd_row,
   output logic [4:0]            rd_col,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [2:0]            out_map,
   output logic                  out_map_last,
   output logic                  out_last,
   output logic                  stream_done,
   output logic                  err_neg,
   output logic                  err_done_lost
);

   rsr_state_t state;
   logic       pending;
   logic       capture;
   logic       advance;
   logic       map_last;
   logic       frame_last;

   assign capture = !out_valid || out_ready;
   assign advance = (state == STREAM) && capture && pending;

   rsr_addr_counter #(
      .NUM_MAPS (NUM_MAPS),
      .MAP_X    (MAP_X),
      .MAP_Y    (MAP_Y)
   ) u_addr (
      .clk        (clk),
      .rst        (rst),
      .clr        (state == IDLE),
      .adv        (advance),
      .map        (rd_map),
      .row        (rd_row),
      .col        (rd_col),
      .map_last   (map_last),
      .frame_last (frame_last)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         pending       <= 1'b0;
         busy          <= 1'b0;
         relu_enable   <= 1'b0;
         out_valid     <= 1'b0;
         out_data      <= '0;
         out_map       <= '0;
         out_map_last  <= 1'b0;
         out_last      <= 1'b0;
         stream_done   <= 1'b0;
         err_neg       <= 1'b0;
         err_done_lost <= 1'b0;
      end else begin
         stream_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state         <= ENABLE;
                  busy          <= 1'b1;
                  relu_enable   <= 1'b1;
                  err_neg       <= 1'b0;
                  err_done_lost <= 1'b0;
               end
            end
            ENABLE: begin
               if (relu_done) begin
                  state   <= STREAM;
                  pending <= 1'b1;
               end
            end
            STREAM: begin
               if (!relu_done)
                  err_done_lost <= 1'b1;
               if (out_valid && out_ready && out_last) begin
                  state        <= DONE;
                  out_valid    <= 1'b0;
                  out_last     <= 1'b0;
                  out_map_last <= 1'b0;
                  relu_enable  <= 1'b0;
                  stream_done  <= 1'b1;
               end else if (capture && pending) begin
                  out_valid    <= 1'b1;
                  out_data     <= rd_data;
                  out_map      <= rd_map;
                  out_map_last <= map_last;
                  out_last     <= frame_last;
                  if (rd_data[DATA_WIDTH-1])
                     err_neg <= 1'b1;
                  if (frame_last)
                     pending <= 1'b0;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_relu_stream_reader.sv
// Randomized frame-level bench: the element source is a value table indexed by address, beats are
// checked against index arithmetic over the whole frame.
module tb_relu_stream_reader;

   localparam int MAPS    = 8;
   localparam int MX      = 24;
   localparam int MY      = 24;
   localparam int MAPSZ   = MX * MY;
   localparam int FRAME   = MAPS * MAPSZ;
   localparam int NEG_IDX = 3 * MAPSZ + 5 * MY + 7;
   localparam logic [44:0] NEG_VAL = {1'b1, 44'h0};

   logic        clk = 1'b0;
   logic        rst, start, relu_done, out_ready;
   logic        busy, relu_enable, out_valid, out_map_last, out_last;
   logic        stream_done, err_neg, err_done_lost;
   logic [2:0]  rd_map, out_map;
   logic [4:0]  rd_row, rd_col;
   logic [44:0] rd_data, out_data;
   logic [44:0] salt;
   logic        inject;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   relu_stream_reader dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .relu_enable(relu_enable),
      .relu_done(relu_done), .rd_map(rd_map), .rd_row(rd_row), .rd_col(rd_col),
      .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_map(out_map), .out_map_last(out_map_last), .out_last(out_last),
      .stream_done(stream_done), .err_neg(err_neg), .err_done_lost(err_done_lost)
   );

   // Element memory seen through the wrapper's mux.
   always_comb begin
      rd_data = (45'(rd_map) * 45'd1000 + 45'(rd_row) * 45'd24 + 45'(rd_col)) ^ salt;
      if (inject && rd_map == 3'd3 && rd_row == 5'd5 && rd_col == 5'd7)
         rd_data = NEG_VAL;
   end

   function automatic logic [44:0] ref_val(input int k);
      int m, r, c;
      m = k / MAPSZ;
      r = (k % MAPSZ) / MY;
      c = k % MY;
      if (inject && m == 3 && r == 5 && c == 7)
         return NEG_VAL;
      return 45'(m * 1000 + r * 24 + c) ^ salt;
   endfunction

   function automatic logic [44:0] rsalt();
      return {1'b0, 12'($urandom), 32'($urandom)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_enable"}, relu_enable, 0);
      chk({tag, "_rd_map"}, rd_map, 0);
      chk({tag, "_rd_row"}, rd_row, 0);
      chk({tag, "_rd_col"}, rd_col, 0);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_data"}, out_data, 0);
      chk({tag, "_map"}, out_map, 0);
      chk({tag, "_map_last"}, out_map_last, 0);
      chk({tag, "_last"}, out_last, 0);
      chk({tag, "_stream_done"}, stream_done, 0);
      chk({tag, "_err_neg"}, err_neg, 0);
      chk({tag, "_err_lost"}, err_done_lost, 0);
   endtask

   // Called right after a falling edge with the DUT idle.
   task automatic run_frame(input logic [44:0] s, input bit rnd, input int dly,
                            input int drop_at, input bit neg, input int abort_at, input bit spam);
      int beats, cyc, first_cyc, last_cyc, stall_left;
      bit stalled, stall_used, dropped;
      logic [44:0] pd;
      logic [2:0]  pm, pmap;
      logic [4:0]  prow, pcol;
      salt = s;
      inject = neg;
      beats = 0; cyc = 0; first_cyc = -1; last_cyc = -1; stall_left = 0;
      stalled = 0; stall_used = 0; dropped = 0;
      pd = '0; pm = '0; pmap = '0; prow = '0; pcol = '0;
      out_ready = 1'b1;
      relu_done = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_enable", relu_enable, 1);
      chk("start_clr_neg", err_neg, 0);
      chk("start_clr_lost", err_done_lost, 0);
      for (int i = 0; i < dly; i++) begin
         chk("wait_valid", out_valid, 0);
         chk("wait_busy", busy, 1);
         chk("wait_enable", relu_enable, 1);
         @(negedge clk);
      end
      relu_done = 1'b1;
      while (beats < FRAME && cyc < 30000) begin
         @(negedge clk);
         if (beats == abort_at) begin
            rst = 1'b0;
            @(negedge clk);
            chk_zero("abort");
            rst = 1'b1;
            relu_done = 1'b0;
            out_ready = 1'b1;
            repeat (20) begin
               @(negedge clk);
               chk("abort_busy", busy, 0);
               chk("abort_no_done", stream_done, 0);
            end
            return;
         end
         if (stalled) begin
            chk("stall_data", out_data, pd);
            chk("stall_map", out_map, pm);
            chk("stall_rd_map", rd_map, pmap);
            chk("stall_rd_row", rd_row, prow);
            chk("stall_rd_col", rd_col, pcol);
         end
         chk("no_early_done", stream_done, 0);
         chk("stream_enable", relu_enable, 1);
         relu_done = 1'b1;
         if (beats == drop_at && !dropped) begin
            relu_done = 1'b0;
            dropped = 1;
         end
         if (rnd) begin
            if (beats == 100 && !stall_used) begin
               stall_left = 10;
               stall_used = 1;
            end
            if (stall_left > 0) begin
               out_ready = 1'b0;
               stall_left--;
            end else begin
               out_ready = ($urandom_range(3) != 0);
            end
         end else begin
            out_ready = 1'b1;
         end
         start = spam && (cyc % 7 == 3);
         if (out_valid && first_cyc < 0)
            first_cyc = cyc;
         if (out_valid && out_ready) begin
            chk("beat_data", out_data, ref_val(beats));
            chk("beat_map", out_map, beats / MAPSZ);
            chk("beat_map_last", out_map_last, (beats % MAPSZ) == MAPSZ - 1);
            chk("beat_last", out_last, beats == FRAME - 1);
            if (neg && beats == NEG_IDX - 1) chk("neg_before", err_neg, 0);
            if (neg && beats == NEG_IDX) chk("neg_onset", err_neg, 1);
            beats++;
            if (beats == FRAME) last_cyc = cyc;
         end
         stalled = out_valid && !out_ready;
         pd = out_data; pm = out_map; pmap = rd_map; prow = rd_row; pcol = rd_col;
         cyc++;
      end
      chk("beat_count", beats, FRAME);
      if (beats != FRAME) begin
         start = 1'b0;
         return;
      end
      chk("first_valid_cycle", first_cyc, 1);
      if (!rnd) chk("gap_free_span", last_cyc - first_cyc + 1, FRAME);
      start = spam;
      @(negedge clk);
      chk("done_pulse", stream_done, 1);
      chk("done_enable_low", relu_enable, 0);
      chk("done_valid_low", out_valid, 0);
      chk("done_busy", busy, 1);
      start = spam;
      @(negedge clk);
      start = 1'b0;
      chk("done_single", stream_done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_enable", relu_enable, 0);
      chk("end_err_neg", err_neg, neg);
      chk("end_err_lost", err_done_lost, drop_at >= 0);
      repeat (5) begin
         @(negedge clk);
         chk("idle_stays", busy, 0);
      end
      relu_done = 1'b0;
   endtask

   initial begin
      rst = 1'b0; start = 1'b1; relu_done = 1'b0; out_ready = 1'b0;
      salt = '0; inject = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b1;
      start = 1'b0;
      repeat (20) begin
         @(negedge clk);
         chk("idle_no_start_busy", busy, 0);
         chk("idle_no_start_enable", relu_enable, 0);
      end
      run_frame('0, 0, 2, -1, 0, -1, 0);
      run_frame(rsalt(), 1, 2, -1, 0, -1, 0);
      run_frame(rsalt(), 0, 50, 1234, 1, -1, 0);
      run_frame(rsalt(), 0, 3, -1, 0, -1, 1);
      run_frame(rsalt(), 1, 2, -1, 0, 2000, 0);
      run_frame(rsalt(), 1, 4, -1, 0, -1, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
